// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per clock, LSB first,
// and publishes the difference and final borrow together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // One spare counter bit so the terminal compare is reached before any wrap.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic a_bit, b_bit, d_bit, br_next;

    assign a_bit   = a_sh_q[0];
    assign b_bit   = b_sh_q[0];
    assign d_bit   = a_bit ^ b_bit ^ br_q;
    assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        diff_d   = diff_q;
        br_d     = br_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + 1'b1;
                // Publish only the completed word, never a partial result.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
